// File: rtl/frame_position_latch.sv
// frame_position_latch
//   Snapshots physics-engine sprite positions at vertical blank, converts
//   each sprite's fixed-point (x, y) into clamped screen (col, row) one
//   sprite per cycle into a back buffer, then commits all sprites at once
//   so the displayed frame never shows a partial update.
//
// Ports
//   clock_162      in   system clock
//   rst            in   synchronous active-high reset
//   locations      in   [SPRITES][DIMENSIONS][WIDTH] signed fixed-point positions
//   loc_valid      in   locations are coherent
//   vblank_start   in   one-cycle pulse at start of vertical blank
//   sprite_row     out  [SPRITES][11] committed screen row
//   sprite_col     out  [SPRITES][12] committed screen column
//   frame_done     out  one-cycle pulse after a commit
//   busy           out  high while a frame is in progress
//   overrun_count  out  saturating count of dropped/skipped vblank pulses
module frame_position_latch #(
    parameter int SPRITES    = 2,
    parameter int DIMENSIONS = 2,
    parameter int WIDTH      = 32,
    parameter int H_CENTER   = 800,
    parameter int V_CENTER   = 600,
    parameter int H_MAX      = 1599,
    parameter int V_MAX      = 1199
) (
    input  logic                                         clock_162,
    input  logic                                         rst,
    input  logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] locations,
    input  logic                                         loc_valid,
    input  logic                                         vblank_start,
    output logic [SPRITES-1:0][10:0]                     sprite_row,
    output logic [SPRITES-1:0][11:0]                     sprite_col,
    output logic                                         frame_done,
    output logic                                         busy,
    output logic [7:0]                                   overrun_count
);

    localparam int HALF  = WIDTH / 2;
    localparam int HW    = HALF + 2;
    localparam int IDX_W = (SPRITES > 1) ? $clog2(SPRITES) : 1;

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [SPRITES-1:0][HALF-1:0]    snap_x_q, snap_x_d;
    logic [SPRITES-1:0][HALF-1:0]    snap_y_q, snap_y_d;
    logic [SPRITES-1:0][10:0]        bb_row_q, bb_row_d;
    logic [SPRITES-1:0][11:0]        bb_col_q, bb_col_d;
    logic [SPRITES-1:0][10:0]        row_q, row_d;
    logic [SPRITES-1:0][11:0]        col_q, col_d;
    logic                            done_q, done_d;
    logic [7:0]                      ovr_q, ovr_d;

    logic signed [HALF-1:0]          x_int, y_int;
    logic signed [HW-1:0]            col_full, row_full;
    logic [11:0]                     col_conv;
    logic [10:0]                     row_conv;

    // Fraction bits (and any axis beyond y) do not feed the screen position.
    logic [SPRITES-1:0][DIMENSIONS-1:0] loc_unused;

    always_comb begin
        loc_unused = '0;
        for (int s = 0; s < SPRITES; s++) begin
            for (int d = 0; d < DIMENSIONS; d++) begin
                loc_unused[s][d] = (d < 2) ? ^locations[s][d][HALF-1:0] : ^locations[s][d];
            end
        end
    end

    // Conversion of the snapshot entry selected by idx. Two guard bits keep
    // center +/- integer part from overflowing before the clamp.
    always_comb begin
        x_int    = snap_x_q[idx_q];
        y_int    = snap_y_q[idx_q];
        col_full = HW'(H_CENTER) + {{2{x_int[HALF-1]}}, x_int};
        row_full = HW'(V_CENTER) - {{2{y_int[HALF-1]}}, y_int};

        if (col_full < 0)                        col_conv = '0;
        else if (col_full > $signed(HW'(H_MAX))) col_conv = 12'(H_MAX);
        else                                     col_conv = 12'(col_full);

        if (row_full < 0)                        row_conv = '0;
        else if (row_full > $signed(HW'(V_MAX))) row_conv = 11'(V_MAX);
        else                                     row_conv = 11'(row_full);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        snap_x_d = snap_x_q;
        snap_y_d = snap_y_q;
        bb_row_d = bb_row_q;
        bb_col_d = bb_col_q;
        row_d    = row_q;
        col_d    = col_q;
        done_d   = 1'b0;
        ovr_d    = ovr_q;

        // A pulse is lost if we are mid-frame or the engine is mid-update.
        if (vblank_start && (state_q != IDLE || !loc_valid) && ovr_q != 8'hFF)
            ovr_d = ovr_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (vblank_start && loc_valid) begin
                    for (int s = 0; s < SPRITES; s++) begin
                        snap_x_d[s] = locations[s][0][WIDTH-1:HALF];
                        snap_y_d[s] = locations[s][1][WIDTH-1:HALF];
                    end
                    idx_d   = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                bb_row_d[idx_q] = row_conv;
                bb_col_d[idx_q] = col_conv;
                idx_d           = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(SPRITES - 1))
                    state_d = COMMIT;
            end
            COMMIT: begin
                row_d   = bb_row_q;
                col_d   = bb_col_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_162) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            snap_x_q <= '0;
            snap_y_q <= '0;
            bb_row_q <= {SPRITES{11'(V_CENTER)}};
            bb_col_q <= {SPRITES{12'(H_CENTER)}};
            row_q    <= {SPRITES{11'(V_CENTER)}};
            col_q    <= {SPRITES{12'(H_CENTER)}};
            done_q   <= 1'b0;
            ovr_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            snap_x_q <= snap_x_d;
            snap_y_q <= snap_y_d;
            bb_row_q <= bb_row_d;
            bb_col_q <= bb_col_d;
            row_q    <= row_d;
            col_q    <= col_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
        end
    end

    assign sprite_row    = row_q;
    assign sprite_col    = col_q;
    assign frame_done    = done_q;
    assign busy          = (state_q != IDLE);
    assign overrun_count = ovr_q;

endmodule

// File: tb/tb_frame_position_latch.sv
module tb_frame_position_latch;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0][1:0][31:0] loc;
    logic                  loc_valid;
    logic                  vblank;
    logic [1:0][10:0]      row;
    logic [1:0][11:0]      col;
    logic                  frame_done;
    logic                  busy;
    logic [7:0]            ovr;

    int total = 0;
    int bad   = 0;

    frame_position_latch dut (
        .clock_162     (clk),
        .rst           (rst),
        .locations     (loc),
        .loc_valid     (loc_valid),
        .vblank_start  (vblank),
        .sprite_row    (row),
        .sprite_col    (col),
        .frame_done    (frame_done),
        .busy          (busy),
        .overrun_count (ovr)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input int r0, input int c0, input int r1, input int c1);
        chk({tag, "_row0"}, 32'(row[0]), r0);
        chk({tag, "_col0"}, 32'(col[0]), c0);
        chk({tag, "_row1"}, 32'(row[1]), r1);
        chk({tag, "_col1"}, 32'(col[1]), c1);
    endtask

    initial begin
        // Reset with a vblank pulse present: it must be ignored.
        rst = 1'b1; loc = '0; loc_valid = 1'b1; vblank = 1'b1;
        step(); step();
        rst = 1'b0; vblank = 1'b0;
        chk_pos("reset", 600, 800, 600, 800);
        chk("reset_done", 32'(frame_done), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ovr", 32'(ovr), 0);

        // Idle 10 cycles: no frame_done, nothing changes.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_done", 32'(frame_done), 0);
        end
        chk_pos("idle", 600, 800, 600, 800);
        chk("idle_ovr", 32'(ovr), 0);

        // x = +256 and -256, y = 0.
        loc[0][0] = 32'h0100_0000; loc[0][1] = 32'h0;
        loc[1][0] = 32'hFF00_0000; loc[1][1] = 32'h0;
        vblank = 1'b1;
        step();                       // edge N: capture
        vblank = 1'b0;
        chk("f1_busy", 32'(busy), 1);
        step();                       // N+1
        chk("f1_done_n1", 32'(frame_done), 0);
        chk_pos("f1_hold", 600, 800, 600, 800);
        step();                       // N+2
        chk("f1_done_n2", 32'(frame_done), 0);
        chk_pos("f1_hold2", 600, 800, 600, 800);
        step();                       // N+3: committed
        chk("f1_done", 32'(frame_done), 1);
        chk("f1_busy_after", 32'(busy), 0);
        chk_pos("f1", 600, 1056, 600, 544);
        step();
        chk("f1_done_pulse", 32'(frame_done), 0);

        // Clamp checks at both extremes.
        loc[0][0] = 32'h7FFF_0000; loc[0][1] = 32'hFD44_0000;
        loc[1][0] = 32'h8000_0000; loc[1][1] = 32'h02BC_0000;
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        step(); step(); step();
        chk("f2_done", 32'(frame_done), 1);
        chk_pos("f2", 1199, 1599, 0, 0);

        // Second pulse one cycle after capture, locations change after the
        // snapshot. Sprite 1 has negative fractions: x=-0.5 -> -1, y~-0 -> -1.
        loc[0][0] = 32'h0010_0000; loc[0][1] = 32'h0005_0000;
        loc[1][0] = 32'hFFFF_8000; loc[1][1] = 32'hFFFF_FFFF;
        vblank = 1'b1;
        step();                       // N: capture
        loc = '0;
        step();                       // N+1: pulse while converting
        vblank = 1'b0;
        chk("f3_ovr", 32'(ovr), 1);
        step();                       // N+2
        chk("f3_done_early", 32'(frame_done), 0);
        step();                       // N+3
        chk("f3_done", 32'(frame_done), 1);
        chk_pos("f3", 595, 816, 601, 799);
        step();
        chk("f3_no_second", 32'(busy), 0);

        // Pulse with loc_valid low: dropped, outputs unchanged.
        loc[0][0] = 32'h0100_0000;
        loc_valid = 1'b0; vblank = 1'b1;
        step();
        vblank = 1'b0;
        chk("drop_busy", 32'(busy), 0);
        chk("drop_ovr", 32'(ovr), 2);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drop_done", 32'(frame_done), 0);
        end
        chk_pos("drop", 595, 816, 601, 799);

        // Saturation: 100 more drops -> 102, then 200 more -> 255.
        vblank = 1'b1;
        for (int i = 0; i < 100; i++) step();
        chk("ovr_mid", 32'(ovr), 102);
        for (int i = 0; i < 200; i++) step();
        vblank = 1'b0;
        chk("ovr_sat", 32'(ovr), 255);
        step();
        chk("ovr_hold", 32'(ovr), 255);

        // Reset the cycle after capture: frame aborted.
        loc_valid = 1'b1;
        loc[0][0] = 32'h0100_0000; loc[1][0] = 32'hFF00_0000;
        vblank = 1'b1;
        step();                       // capture
        vblank = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ovr", 32'(ovr), 0);
        chk_pos("abort_rst", 600, 800, 600, 800);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_done", 32'(frame_done), 0);
        end
        chk_pos("abort", 600, 800, 600, 800);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
